// File: rtl/compressor_pkg.sv
// compressor_pkg: shared definitions for the carry-save multiply sequencer.
//   state_e          - sequencer FSM state encoding
//   PP_PER_CYCLE     - partial products folded into the accumulators per cycle
//   iter_cnt_width() - iteration counter width for a given operand width
package compressor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMPRESS = 2'd1,
    ST_RESOLVE  = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int unsigned PP_PER_CYCLE = 2;

  // One counter value per COMPRESS iteration (WIDTH/2 of them), never narrower than 1 bit.
  function automatic int unsigned iter_cnt_width(input int unsigned w);
    return ((w / 2) > 1) ? $clog2(w / 2) : 1;
  endfunction

endpackage

// File: rtl/compressor_4_2_row.sv
// compressor_4_2_row: one 2*WIDTH-bit row of 4:2 compressor cells.
//   WIDTH    - operand width; the row is 2*WIDTH bits wide
//   x0_i..x3_i - four addends of equal weight per bit
//   sum_o    - per-bit sum output
//   carry_o  - per-bit carry output (weight of bit i+1, not yet shifted)
// The cell cout ripples into the next cell's cin; cout of the top bit is dropped,
// which makes the row arithmetic modulo 2^(2*WIDTH).
module compressor_4_2_row #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] x0_i,
  input  logic [2*WIDTH-1:0] x1_i,
  input  logic [2*WIDTH-1:0] x2_i,
  input  logic [2*WIDTH-1:0] x3_i,
  output logic [2*WIDTH-1:0] sum_o,
  output logic [2*WIDTH-1:0] carry_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] cin;
  logic [PW-1:0] s1;

  assign cin[0] = 1'b0;

  for (genvar i = 0; i < PW; i++) begin : g_cell
    // First full adder folds three addends; its majority is the lateral cout.
    assign s1[i] = x0_i[i] ^ x1_i[i] ^ x2_i[i];
    // Second full adder folds the fourth addend and the incoming cin.
    assign sum_o[i]   = s1[i] ^ x3_i[i] ^ cin[i];
    assign carry_o[i] = (s1[i] & x3_i[i]) | (s1[i] & cin[i]) | (x3_i[i] & cin[i]);
    if (i < PW - 1) begin : g_chain
      assign cin[i+1] = (x0_i[i] & x1_i[i]) | (x0_i[i] & x2_i[i]) | (x1_i[i] & x2_i[i]);
    end
  end

endmodule

// File: rtl/pp_accum_sequencer.sv
// pp_accum_sequencer: sequential unsigned multiplier, two partial products per
// cycle accumulated in carry-save form, resolved with one final addition.
//   WIDTH    - operand width (even, >= 4)
//   clk_i    - clock; rst_i - synchronous active-high reset
//   valid_i / ready_o / a_i / b_i      - operand handshake (accepted only in IDLE)
//   valid_o / ready_i / result_o       - result handshake; result_o is 0 unless valid_o
//   busy_o   - high whenever not IDLE
// Build option: define PP_ACCUM_EARLY_TERM_EN to leave COMPRESS as soon as the
// remaining multiplier bits are all zero (results are identical, latency shrinks).
module pp_accum_sequencer
  import compressor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = iter_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH / 2 - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    carry_q, carry_d;
  logic [PW-1:0]    result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]   sh;
  logic [1:0]    b_pair;
  logic [PW-1:0] a_shift;
  logic [PW-1:0] pp0, pp1;
  logic [PW-1:0] row_sum, row_carry;
  logic          stop_iter;

  // Iteration k consumes multiplier bits 2k and 2k+1.
  assign sh      = 32'(cnt_q) * PP_PER_CYCLE;
  assign b_pair  = 2'(b_q >> sh);
  assign a_shift = {{WIDTH{1'b0}}, a_q} << sh;
  assign pp0     = b_pair[0] ? a_shift        : '0;
  assign pp1     = b_pair[1] ? (a_shift << 1) : '0;

  compressor_4_2_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .x0_i   (sum_q),
    .x1_i   (carry_q),
    .x2_i   (pp0),
    .x3_i   (pp1),
    .sum_o  (row_sum),
    .carry_o(row_carry)
  );

`ifdef PP_ACCUM_EARLY_TERM_EN
  // Nothing left to add once every multiplier bit above 2k+1 is zero.
  assign stop_iter = (cnt_q == LAST_ITER) || ((b_q >> (sh + 32'd2)) == '0);
`else
  assign stop_iter = (cnt_q == LAST_ITER);
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = ST_COMPRESS;
        end
      end
      ST_COMPRESS: begin
        sum_d   = row_sum;
        carry_d = row_carry << 1;
        if (stop_iter) begin
          state_d = ST_RESOLVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESOLVE: begin
        result_d = sum_q + carry_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign busy_o   = (state_q != ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = valid_o ? result_q : '0;

endmodule

// File: tb/tb_pp_accum_sequencer.sv
// Directed bench for pp_accum_sequencer (WIDTH=16). Latency is counted in cycles
// after the accept edge: the cycle right after that edge is cycle 1.
module tb_pp_accum_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  pp_accum_sequencer #(.WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected valid_o latency: COMPRESS iterations + RESOLVE + first DONE cycle.
  function automatic int exp_lat(input logic [15:0] b);
`ifdef PP_ACCUM_EARLY_TERM_EN
    int n;
    n = 1;
    for (int k = 0; k < 8; k++) begin
      if (b[2*k] || b[2*k+1]) n = k + 1;
    end
    return n + 2;
`else
    return (b == b) ? 10 : 0;
`endif
  endfunction

  // Present one operand pair, wait (bounded) for valid_o, check latency and product.
  // With noise set, valid_i/a_i/b_i are scrambled every cycle while busy.
  // Returns with the DUT in DONE, sampled at a negedge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input bit noise);
    int lat;
    bit seen;
    @(negedge clk);
    chk({tag, "_ready_before"}, 64'(ready_o), 64'(1));
    a_i = a; b_i = b; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (valid_o) begin
        seen = 1'b1;
      end else begin
        if (lat == 1) begin
          chk({tag, "_busy"}, 64'(busy_o), 64'(1));
          chk({tag, "_ready_busy"}, 64'(ready_o), 64'(0));
          chk({tag, "_result_gated"}, 64'(result_o), 64'(0));
        end
        if (noise) begin
          valid_i = 1'($urandom);
          a_i = 16'($urandom);
          b_i = 16'($urandom);
        end
      end
    end
    valid_i = 1'b0;
    chk({tag, "_valid_seen"}, 64'(seen), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({tag, "_result"}, 64'(result_o), 64'(exp));
  endtask

  // Complete the output handshake (ready_i assumed high) and check IDLE outputs.
  task automatic finish_op(input string tag);
    @(negedge clk);
    chk({tag, "_idle_ready"}, 64'(ready_o), 64'(1));
    chk({tag, "_idle_valid"}, 64'(valid_o), 64'(0));
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    bit vseen;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'(1));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));

    // Basic product
    run_op("mul3x5", 16'h0003, 16'h0005, 32'h0000_000F, 1'b0);
    finish_op("mul3x5");

    // Full-width operands, maximal carry activity
    run_op("mulmax", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
    finish_op("mulmax");

    // Downstream stall: hold ready_i low for 5 cycles in DONE
    ready_i = 1'b0;
    run_op("stall", 16'h00A5, 16'h0102, 32'h0000_A64A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(valid_o), 64'(1));
      chk("stall_result", 64'(result_o), 64'(32'h0000_A64A));
      chk("stall_ready", 64'(ready_o), 64'(0));
    end
    // valid_i high during the release cycle must not be taken
    ready_i = 1'b1;
    valid_i = 1'b1; a_i = 16'h0007; b_i = 16'h0007;
    @(negedge clk);
    chk("release_ready", 64'(ready_o), 64'(1));
    chk("release_busy", 64'(busy_o), 64'(0));
    chk("release_result", 64'(result_o), 64'(0));
    valid_i = 1'b0;

    // Reset mid-operation
    @(negedge clk);
    a_i = 16'h1234; b_i = 16'h5678; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(ready_o), 64'(1));
    chk("midrst_busy", 64'(busy_o), 64'(0));
    vseen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (valid_o) vseen = 1'b1;
    end
    chk("midrst_no_valid", 64'(vseen), 64'(0));
    run_op("after_rst", 16'h0002, 16'h0003, 32'h0000_0006, 1'b0);
    finish_op("after_rst");

    // Input activity while busy is ignored
    run_op("noise", 16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b1);
    finish_op("noise");

    // Small multiplier (shortest path when early termination is built in)
    run_op("small_b", 16'h1234, 16'h0001, 32'h0000_1234, 1'b0);
    finish_op("small_b");

    // Zero multiplier
    run_op("zero_b", 16'hBEEF, 16'h0000, 32'h0000_0000, 1'b0);
    finish_op("zero_b");

    // Only the top multiplier bit set
    run_op("top_b", 16'h8001, 16'h8000, 32'h4000_8000, 1'b0);
    finish_op("top_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
